// File: rtl/cu_defs.sv
// Shared opcode, ALU-code, instruction-class and state encodings for the hardwired control unit.
package cu_defs;

  localparam int unsigned OP_W  = 5;
  localparam int unsigned ALU_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_SHR  = 5'b00111,
    OP_SHL  = 5'b01000,
    OP_ROR  = 5'b01001,
    OP_ROL  = 5'b01010,
    OP_ADDI = 5'b01100,
    OP_ANDI = 5'b01101,
    OP_ORI  = 5'b01110,
    OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010,
    OP_NOP  = 5'b11010,
    OP_HALT = 5'b11011
  } opcode_e;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_SHR = 4'h4,
    ALU_SHL = 4'h5,
    ALU_ROR = 4'h6,
    ALU_ROL = 4'h7,
    ALU_MUL = 4'h8,
    ALU_DIV = 4'h9,
    ALU_NEG = 4'hA,
    ALU_NOT = 4'hB
  } alu_e;

  typedef enum logic [2:0] {
    CL_REG,
    CL_IMM,
    CL_UNARY,
    CL_MULDIV,
    CL_NOP,
    CL_HALT
  } iclass_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T1W,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_e;

  // Single-bit datapath strobes plus the ALU select, registered as one word
  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic zhigh_out;
    logic hi_out;
    logic lo_out;
    logic mdr_out;
    logic c_out;
    logic mar_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic hi_in;
    logic lo_in;
    logic inc_pc;
    logic read;
    logic zin_low;
    logic zin_high;
    alu_e operation;
  } strobe_t;

endpackage

// File: rtl/cu_decode.sv
// Opcode decoder: maps the 5-bit op field to an instruction class and ALU function.
module cu_decode
  import cu_defs::*;
(
  input  logic [OP_W-1:0] op,
  output iclass_e         op_class,
  output alu_e            alu_op,
  output logic            valid
);

  always_comb begin
    op_class = CL_NOP;
    alu_op   = ALU_ADD;
    valid    = 1'b1;
    case (op)
      OP_ADD:  begin op_class = CL_REG;    alu_op = ALU_ADD; end
      OP_SUB:  begin op_class = CL_REG;    alu_op = ALU_SUB; end
      OP_AND:  begin op_class = CL_REG;    alu_op = ALU_AND; end
      OP_OR:   begin op_class = CL_REG;    alu_op = ALU_OR;  end
      OP_SHR:  begin op_class = CL_REG;    alu_op = ALU_SHR; end
      OP_SHL:  begin op_class = CL_REG;    alu_op = ALU_SHL; end
      OP_ROR:  begin op_class = CL_REG;    alu_op = ALU_ROR; end
      OP_ROL:  begin op_class = CL_REG;    alu_op = ALU_ROL; end
      OP_ADDI: begin op_class = CL_IMM;    alu_op = ALU_ADD; end
      OP_ANDI: begin op_class = CL_IMM;    alu_op = ALU_AND; end
      OP_ORI:  begin op_class = CL_IMM;    alu_op = ALU_OR;  end
      OP_MUL:  begin op_class = CL_MULDIV; alu_op = ALU_MUL; end
      OP_DIV:  begin op_class = CL_MULDIV; alu_op = ALU_DIV; end
      OP_NEG:  begin op_class = CL_UNARY;  alu_op = ALU_NEG; end
      OP_NOT:  begin op_class = CL_UNARY;  alu_op = ALU_NOT; end
      OP_NOP:  op_class = CL_NOP;
      OP_HALT: op_class = CL_HALT;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer driving the DataPath strobes; outputs are registered
// from the next state so every strobe lines up exactly with the state that owns it.
module control_unit
  import cu_defs::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned NREGS       = 16
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             run_in,
  input  logic             mem_ready,
  input  logic [31:0]      ir,
  output logic             PCout,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIout,
  output logic             LOout,
  output logic             MDRout,
  output logic             Cout,
  output logic [NREGS-1:0] Rout,
  output logic             MARin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             HIin,
  output logic             LOin,
  output logic [NREGS-1:0] Rin,
  output logic             IncPC,
  output logic             Read,
  output logic             Zin_low,
  output logic             Zin_high,
  output logic [ALU_W-1:0] operation,
  output logic             run,
  output logic             illegal,
  output logic             mem_err
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e           state, nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
  strobe_t          ctrl_q, ctrl_d;
  logic [NREGS-1:0] rin_q, rin_d, rout_q, rout_d;
  logic             run_q, run_d, illegal_q, illegal_d, mem_err_q, mem_err_d;
  iclass_e          op_class;
  alu_e             alu_op;
  logic             op_valid, is_alu, is_muldiv;
  logic [NREGS-1:0] ra_oh, rb_oh, rc_oh;
  logic             unused_ir;

  cu_decode u_decode (
    .op       (ir[31:27]),
    .op_class (op_class),
    .alu_op   (alu_op),
    .valid    (op_valid)
  );

  assign ra_oh     = NREGS'(1) << ir[26:23];
  assign rb_oh     = NREGS'(1) << ir[22:19];
  assign rc_oh     = NREGS'(1) << ir[18:15];
  assign is_muldiv = op_valid && (op_class == CL_MULDIV);
  assign is_alu    = op_valid && (op_class != CL_NOP) && (op_class != CL_HALT);
  assign unused_ir = ^ir[14:0];

  // Next state, then the strobes that belong to that next state
  always_comb begin
    nxt        = state;
    wait_cnt_d = wait_cnt;
    illegal_d  = illegal_q;
    mem_err_d  = mem_err_q;
    case (state)
      S_IDLE: if (run_in) nxt = S_T0;
      S_T0:   nxt = S_T1;
      S_T1: begin
        if (mem_ready) begin
          nxt = S_T2;
        end else begin
          nxt        = S_T1W;
          wait_cnt_d = CNT_W'(1);
        end
      end
      S_T1W: begin
        if (mem_ready) begin
          nxt        = S_T2;
          wait_cnt_d = '0;
        end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
          nxt        = S_HALT;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + CNT_W'(1);
        end
      end
      S_T2: nxt = S_T3;
      S_T3: begin
        if (!op_valid) begin
          nxt       = S_HALT;
          illegal_d = 1'b1;
        end else if (op_class == CL_HALT) begin
          nxt = S_HALT;
        end else if (op_class == CL_NOP) begin
          nxt = run_in ? S_T0 : S_IDLE;
        end else begin
          nxt = S_T4;
        end
      end
      S_T4:    nxt = S_T5;
      S_T5:    nxt = is_muldiv ? S_T6 : (run_in ? S_T0 : S_IDLE);
      S_T6:    nxt = run_in ? S_T0 : S_IDLE;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase

    ctrl_d = '0;
    rin_d  = '0;
    rout_d = '0;
    run_d  = (nxt != S_IDLE) && (nxt != S_HALT);
    case (nxt)
      S_T0: begin
        ctrl_d.pc_out  = 1'b1;
        ctrl_d.mar_in  = 1'b1;
        ctrl_d.inc_pc  = 1'b1;
        ctrl_d.zin_low = 1'b1;
      end
      S_T1: begin
        ctrl_d.zlow_out = 1'b1;
        ctrl_d.pc_in    = 1'b1;
        ctrl_d.read     = 1'b1;
        ctrl_d.mdr_in   = 1'b1;
      end
      S_T1W: begin
        ctrl_d.read   = 1'b1;
        ctrl_d.mdr_in = 1'b1;
      end
      S_T2: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_in   = 1'b1;
      end
      S_T3: begin
        if (is_alu) begin
          rout_d      = rb_oh;
          ctrl_d.y_in = 1'b1;
        end
      end
      S_T4: begin
        ctrl_d.operation = alu_op;
        ctrl_d.zin_low   = 1'b1;
        case (op_class)
          CL_REG:   rout_d = rc_oh;
          CL_IMM:   ctrl_d.c_out = 1'b1;
          CL_UNARY: rout_d = rb_oh;
          CL_MULDIV: begin
            rout_d          = ra_oh;
            ctrl_d.zin_high = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        ctrl_d.zlow_out = 1'b1;
        if (is_muldiv) ctrl_d.lo_in = 1'b1;
        else           rin_d = ra_oh;
      end
      S_T6: begin
        ctrl_d.zhigh_out = 1'b1;
        ctrl_d.hi_in     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      ctrl_q    <= '0;
      rin_q     <= '0;
      rout_q    <= '0;
      run_q     <= 1'b0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= nxt;
      wait_cnt  <= wait_cnt_d;
      ctrl_q    <= ctrl_d;
      rin_q     <= rin_d;
      rout_q    <= rout_d;
      run_q     <= run_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign PCout     = ctrl_q.pc_out;
  assign Zlowout   = ctrl_q.zlow_out;
  assign Zhighout  = ctrl_q.zhigh_out;
  assign HIout     = ctrl_q.hi_out;
  assign LOout     = ctrl_q.lo_out;
  assign MDRout    = ctrl_q.mdr_out;
  assign Cout      = ctrl_q.c_out;
  assign MARin     = ctrl_q.mar_in;
  assign PCin      = ctrl_q.pc_in;
  assign MDRin     = ctrl_q.mdr_in;
  assign IRin      = ctrl_q.ir_in;
  assign Yin       = ctrl_q.y_in;
  assign HIin      = ctrl_q.hi_in;
  assign LOin      = ctrl_q.lo_in;
  assign IncPC     = ctrl_q.inc_pc;
  assign Read      = ctrl_q.read;
  assign Zin_low   = ctrl_q.zin_low;
  assign Zin_high  = ctrl_q.zin_high;
  assign operation = ctrl_q.operation;
  assign Rout      = rout_q;
  assign Rin       = rin_q;
  assign run       = run_q;
  assign illegal   = illegal_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: a per-instruction expected strobe timeline is built
// from the instruction-level rules and compared against the DUT every cycle.
module tb_control_unit;

  localparam int unsigned NREGS       = 16;
  localparam int unsigned MEM_TIMEOUT = 15;

  typedef struct packed {
    logic        run;
    logic        illegal;
    logic        mem_err;
    logic        pcout;
    logic        zlowout;
    logic        zhighout;
    logic        hiout;
    logic        loout;
    logic        mdrout;
    logic        cout;
    logic        marin;
    logic        pcin;
    logic        mdrin;
    logic        irin;
    logic        yin;
    logic        hiin;
    logic        loin;
    logic        incpc;
    logic        read;
    logic        zin_low;
    logic        zin_high;
    logic [3:0]  operation;
    logic [15:0] rout;
    logic [15:0] rin;
  } obs_t;

  localparam int unsigned OBS_W = $bits(obs_t);

  localparam int K_REG = 0, K_IMM = 1, K_UN = 2, K_MD = 3, K_NOP = 4, K_HALT = 5, K_ILL = 6;

  logic        Clock, clear, run_in, mem_ready;
  logic [31:0] ir;
  logic        PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout;
  logic [15:0] Rout, Rin;
  logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin;
  logic        IncPC, Read, Zin_low, Zin_high;
  logic [3:0]  operation;
  logic        run, illegal, mem_err;

  control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .NREGS(NREGS)) dut (
    .Clock(Clock), .clear(clear), .run_in(run_in), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .Cout(Cout), .Rout(Rout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .Rin(Rin), .IncPC(IncPC),
    .Read(Read), .Zin_low(Zin_low), .Zin_high(Zin_high), .operation(operation),
    .run(run), .illegal(illegal), .mem_err(mem_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   idle;
  bit   ends_halted;
  obs_t exp_q[$];

  logic [4:0] legal_ops [16] = '{5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
                                 5'h0C, 5'h0D, 5'h0E, 5'h0F, 5'h10, 5'h11, 5'h12, 5'h1A};

  function automatic obs_t get_obs();
    obs_t o;
    o = '{run: run, illegal: illegal, mem_err: mem_err, pcout: PCout, zlowout: Zlowout,
          zhighout: Zhighout, hiout: HIout, loout: LOout, mdrout: MDRout, cout: Cout,
          marin: MARin, pcin: PCin, mdrin: MDRin, irin: IRin, yin: Yin, hiin: HIin,
          loin: LOin, incpc: IncPC, read: Read, zin_low: Zin_low, zin_high: Zin_high,
          operation: operation, rout: Rout, rin: Rin};
    return o;
  endfunction

  task automatic check(input string tag, input logic [OBS_W-1:0] got,
                       input logic [OBS_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction table: class and ALU code for each opcode
  function automatic void op_info(input logic [4:0] op, output int kind, output logic [3:0] alu);
    alu = 4'h0;
    case (op)
      5'h03: kind = K_REG;
      5'h04: begin kind = K_REG; alu = 4'h1; end
      5'h05: begin kind = K_REG; alu = 4'h2; end
      5'h06: begin kind = K_REG; alu = 4'h3; end
      5'h07: begin kind = K_REG; alu = 4'h4; end
      5'h08: begin kind = K_REG; alu = 4'h5; end
      5'h09: begin kind = K_REG; alu = 4'h6; end
      5'h0A: begin kind = K_REG; alu = 4'h7; end
      5'h0C: kind = K_IMM;
      5'h0D: begin kind = K_IMM; alu = 4'h2; end
      5'h0E: begin kind = K_IMM; alu = 4'h3; end
      5'h0F: begin kind = K_MD;  alu = 4'h8; end
      5'h10: begin kind = K_MD;  alu = 4'h9; end
      5'h11: begin kind = K_UN;  alu = 4'hA; end
      5'h12: begin kind = K_UN;  alu = 4'hB; end
      5'h1A: kind = K_NOP;
      5'h1B: kind = K_HALT;
      default: kind = K_ILL;
    endcase
  endfunction

  function automatic obs_t busy();
    obs_t o = '0;
    o.run = 1'b1;
    return o;
  endfunction

  // Expected cycle-by-cycle strobes for one instruction with w not-ready fetch cycles
  function automatic void build(input logic [31:0] irv, input int w);
    obs_t       o;
    int         kind;
    logic [3:0] alu;
    logic [3:0] ra, rb, rc;
    ra = irv[26:23];
    rb = irv[22:19];
    rc = irv[18:15];
    exp_q.delete();
    ends_halted = 1'b0;
    o = busy(); o.pcout = 1; o.marin = 1; o.incpc = 1; o.zin_low = 1; exp_q.push_back(o);
    o = busy(); o.zlowout = 1; o.pcin = 1; o.read = 1; o.mdrin = 1; exp_q.push_back(o);
    for (int i = 0; i < ((w > MEM_TIMEOUT) ? MEM_TIMEOUT : w); i++) begin
      o = busy(); o.read = 1; o.mdrin = 1; exp_q.push_back(o);
    end
    if (w > MEM_TIMEOUT) begin
      o = '0; o.mem_err = 1; exp_q.push_back(o);
      ends_halted = 1'b1;
      return;
    end
    o = busy(); o.mdrout = 1; o.irin = 1; exp_q.push_back(o);
    op_info(irv[31:27], kind, alu);
    o = busy();
    if (kind <= K_MD) begin o.rout = 16'(1) << rb; o.yin = 1; end
    exp_q.push_back(o);
    if (kind == K_NOP) return;
    if (kind == K_HALT || kind == K_ILL) begin
      o = '0; o.illegal = (kind == K_ILL); exp_q.push_back(o);
      ends_halted = 1'b1;
      return;
    end
    o = busy(); o.operation = alu; o.zin_low = 1;
    case (kind)
      K_REG:   o.rout = 16'(1) << rc;
      K_IMM:   o.cout = 1;
      K_UN:    o.rout = 16'(1) << rb;
      default: begin o.rout = 16'(1) << ra; o.zin_high = 1; end
    endcase
    exp_q.push_back(o);
    o = busy(); o.zlowout = 1;
    if (kind == K_MD) o.loin = 1;
    else              o.rin = 16'(1) << ra;
    exp_q.push_back(o);
    if (kind == K_MD) begin
      o = busy(); o.zhighout = 1; o.hiin = 1; exp_q.push_back(o);
    end
  endfunction

  task automatic run_instr(input logic [31:0] irv, input int w, input bit cont, input int abort_k);
    int last;
    build(irv, w);
    last = exp_q.size() - 1;
    if (idle) begin
      @(negedge Clock);
      check("idle", get_obs(), '0);
      run_in = 1'b1;
    end
    for (int k = 0; k <= last; k++) begin
      @(negedge Clock);
      check($sformatf("op%02h_w%0d_k%0d", irv[31:27], w, k), get_obs(), exp_q[k]);
      if (k == 0) ir = irv;
      mem_ready = (k >= 1 && k <= w + 1) ? (k - 1 >= w) : 1'($urandom_range(0, 1));
      run_in    = (k == last && !ends_halted) ? cont : 1'($urandom_range(0, 1));
      if (k == abort_k) begin
        clear = 1'b0;
        #1;
        check("clr_async", get_obs(), '0);
        @(negedge Clock);
        check("clr_hold", get_obs(), '0);
        run_in = 1'b0;
        clear  = 1'b1;
        idle   = 1'b1;
        return;
      end
    end
    idle = !ends_halted && !cont;
  endtask

  task automatic halt_hold(input int n, input bit ill, input bit merr);
    obs_t hv = '0;
    hv.illegal = ill;
    hv.mem_err = merr;
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      check($sformatf("halt_%0d", i), get_obs(), hv);
      run_in    = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    clear  = 1'b0;
    run_in = 1'b0;
    #1;
    check("reset_async", get_obs(), '0);
    @(negedge Clock);
    check("reset_hold", get_obs(), '0);
    clear = 1'b1;
    idle  = 1'b1;
  endtask

  initial begin
    logic [31:0] rir;
    int          rw;
    clear = 1'b0; run_in = 1'b0; mem_ready = 1'b0; ir = '0; idle = 1'b1;
    repeat (2) @(negedge Clock);
    check("reset", get_obs(), '0);
    clear = 1'b1;

    run_instr(32'h18918000, 0, 1'b1, -1);
    run_instr(32'h622FFFFD, 0, 1'b1, -1);
    run_instr(32'h7B380000, 0, 1'b0, -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("idle_hold", get_obs(), '0);
    end
    run_instr(32'h18918000, 3, 1'b1, -1);
    run_instr(32'hD0000000, 0, 1'b1, -1);
    run_instr(32'h20000000, 15, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      rir = $urandom;
      rir[31:27] = legal_ops[$urandom_range(0, 15)];
      rw = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 4));
      run_instr(rir, rw, 1'($urandom_range(0, 3) != 0), -1);
    end

    run_instr(32'hD8000000, 0, 1'b1, -1);
    halt_hold(4, 1'b0, 1'b0);
    do_reset();
    run_instr(32'hF8000000, 1, 1'b1, -1);
    halt_hold(4, 1'b1, 1'b0);
    do_reset();
    run_instr(32'h18918000, 0, 1'b1, 4);
    run_instr(32'h18918000, 0, 1'b0, -1);
    run_instr(32'h18918000, 16, 1'b1, -1);
    halt_hold(3, 1'b0, 1'b1);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
